// File: rtl/ap_line_pkg.sv
// Shared definitions for the data-side execution stage: opcode bit positions,
// the execution state encoding and the opcode legality rule.
package ap_line_pkg;

   localparam int OP_W          = 16;
   localparam int OP_NOP        = 0;
   localparam int OP_INC        = 1;
   localparam int OP_DEC        = 2;
   localparam int OP_RIGHT      = 3;
   localparam int OP_LEFT       = 4;
   localparam int OP_LOOP_OPEN  = 5;
   localparam int OP_LOOP_CLOSE = 6;
   localparam int OP_OUT        = 7;
   localparam int OP_IN         = 8;
   localparam int OP_HALT       = 15;

   localparam logic [OP_W-1:0] OP_LEGAL_MASK =
      (16'b1 << OP_NOP) | (16'b1 << OP_INC) | (16'b1 << OP_DEC) |
      (16'b1 << OP_RIGHT) | (16'b1 << OP_LEFT) | (16'b1 << OP_LOOP_OPEN) |
      (16'b1 << OP_LOOP_CLOSE) | (16'b1 << OP_OUT) | (16'b1 << OP_IN) |
      (16'b1 << OP_HALT);

   typedef enum logic [3:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_ACK,
      ST_MV_WR,
      ST_MV_RD,
      ST_MV_LD,
      ST_OUT_WAIT,
      ST_IN_WAIT,
      ST_HALT
   } ap_state_t;

   // An opcode is legal only when exactly one defined bit is set.
   function automatic logic isLegalOpcode(input logic [OP_W-1:0] op);
      return $onehot(op) && ((op & ~OP_LEGAL_MASK) == '0);
   endfunction

endpackage

// File: rtl/ap_line_if.sv
// Opcode handshake and I/O byte channels between the IP line, the tape stage
// and the outside world; master is the upstream/environment side.
interface ap_line_if
   import ap_line_pkg::*;
#(
   parameter int DATA_W = 8
);

   logic [OP_W-1:0]   Opcode;
   logic              OpcodeReady;
   logic              OpcodeAck;
   logic              DataZero;
   logic [DATA_W-1:0] IoOutData;
   logic              IoOutValid;
   logic              IoOutReady;
   logic              IoInReq;
   logic [DATA_W-1:0] IoInData;
   logic              IoInValid;
   logic              Busy;
   logic              Halted;
   logic              Error;

   modport master (
      output Opcode, OpcodeReady, IoOutReady, IoInData, IoInValid,
      input  OpcodeAck, DataZero, IoOutData, IoOutValid, IoInReq, Busy, Halted, Error
   );

   modport slave (
      input  Opcode, OpcodeReady, IoOutReady, IoInData, IoInValid,
      output OpcodeAck, DataZero, IoOutData, IoOutValid, IoInReq, Busy, Halted, Error
   );

endinterface

// File: rtl/ap_ram.sv
// Single-port tape RAM: synchronous write, synchronous read with one cycle of
// latency. Contents are not reset; the CLEAR pass zeroes them.
module ap_ram #(
   parameter int DATA_W = 8,
   parameter int AP_W   = 15
) (
   input  logic              Clk,
   input  logic              we,
   input  logic [AP_W-1:0]   addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [0:(2**AP_W)-1];

   // Read returns the old contents when a write hits the same address.
   always_ff @(posedge Clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/ap_line.sv
// Data-side execution stage: executes one-hot opcodes against the tape,
// caching the current cell in dataReg and spilling it to RAM on pointer moves.
module ap_line
   import ap_line_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int AP_W   = 15
) (
   input  logic    Clk,
   input  logic    Rst_n,
   ap_line_if.slave bus
);

   ap_state_t         state;
   logic [AP_W-1:0]   ap;
   logic [DATA_W-1:0] dataReg;
   logic              moveUp;
   logic              opcodeAck;
   logic [DATA_W-1:0] ioOutData;
   logic              ioOutValid;
   logic              ioInReq;
   logic              busy;
   logic              halted;
   logic              error;

   logic              ramWe;
   logic [DATA_W-1:0] ramWdata;
   logic [DATA_W-1:0] ramRdata;

   // RAM is written while clearing and when the cached cell is spilled.
   assign ramWe    = (state == ST_CLEAR) || (state == ST_MV_WR);
   assign ramWdata = (state == ST_CLEAR) ? '0 : dataReg;

   ap_ram #(
      .DATA_W (DATA_W),
      .AP_W   (AP_W)
   ) uRam (
      .Clk   (Clk),
      .we    (ramWe),
      .addr  (ap),
      .wdata (ramWdata),
      .rdata (ramRdata)
   );

   // Main execution FSM; every handshake output is a register set on entry.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state      <= ST_CLEAR;
         ap         <= '0;
         dataReg    <= '0;
         moveUp     <= 1'b0;
         opcodeAck  <= 1'b0;
         ioOutData  <= '0;
         ioOutValid <= 1'b0;
         ioInReq    <= 1'b0;
         busy       <= 1'b1;
         halted     <= 1'b0;
         error      <= 1'b0;
      end else begin
         unique case (state)
            ST_CLEAR: begin
               if (ap == '1) begin
                  ap    <= '0;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  ap <= ap + AP_W'(1);
               end
            end
            ST_IDLE: begin
               if (bus.OpcodeReady) begin
                  busy      <= 1'b1;
                  opcodeAck <= 1'b1;
                  state     <= ST_ACK;
                  if (!isLegalOpcode(bus.Opcode)) begin
                     error <= 1'b1;
                  end else if (bus.Opcode[OP_INC]) begin
                     dataReg <= dataReg + DATA_W'(1);
                  end else if (bus.Opcode[OP_DEC]) begin
                     dataReg <= dataReg - DATA_W'(1);
                  end else if (bus.Opcode[OP_RIGHT] || bus.Opcode[OP_LEFT]) begin
                     moveUp    <= bus.Opcode[OP_RIGHT];
                     opcodeAck <= 1'b0;
                     state     <= ST_MV_WR;
                  end else if (bus.Opcode[OP_OUT]) begin
                     ioOutData  <= dataReg;
                     ioOutValid <= 1'b1;
                     opcodeAck  <= 1'b0;
                     state      <= ST_OUT_WAIT;
                  end else if (bus.Opcode[OP_IN]) begin
                     ioInReq   <= 1'b1;
                     opcodeAck <= 1'b0;
                     state     <= ST_IN_WAIT;
                  end else if (bus.Opcode[OP_HALT]) begin
                     halted    <= 1'b1;
                     opcodeAck <= 1'b0;
                     state     <= ST_HALT;
                  end
               end
            end
            ST_MV_WR: begin
               ap    <= moveUp ? ap + AP_W'(1) : ap - AP_W'(1);
               state <= ST_MV_RD;
            end
            ST_MV_RD: begin
               state <= ST_MV_LD;
            end
            ST_MV_LD: begin
               dataReg   <= ramRdata;
               opcodeAck <= 1'b1;
               state     <= ST_ACK;
            end
            ST_OUT_WAIT: begin
               if (bus.IoOutReady) begin
                  ioOutValid <= 1'b0;
                  opcodeAck  <= 1'b1;
                  state      <= ST_ACK;
               end
            end
            ST_IN_WAIT: begin
               if (bus.IoInValid) begin
                  dataReg   <= bus.IoInData;
                  ioInReq   <= 1'b0;
                  opcodeAck <= 1'b1;
                  state     <= ST_ACK;
               end
            end
            ST_ACK: begin
               opcodeAck <= 1'b0;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
            ST_HALT: begin
               state <= ST_HALT;
            end
            default: begin
               state <= ST_CLEAR;
            end
         endcase
      end
   end

   assign bus.OpcodeAck  = opcodeAck;
   assign bus.DataZero   = (dataReg == '0);
   assign bus.IoOutData  = ioOutData;
   assign bus.IoOutValid = ioOutValid;
   assign bus.IoInReq    = ioInReq;
   assign bus.Busy       = busy;
   assign bus.Halted     = halted;
   assign bus.Error      = error;

endmodule
